decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode stage for the pipelined datapath. It sits between the fetch register and the execute stage. It decodes each instruction into datapath control words with no don't-cares, holds them in an output pipeline register behind a valid/ready handshake, and handles flush. It also inserts a one-cycle bubble on load-use hazards and counts bubbles and illegal opcodes.

## Interface
- IW, 32, instruction width; must satisfy IW >= 7 + 3*RAW
- RAW, 5, register-address width (DA/AA/BA)
- HAZARD_EN, 1, 1 enables load-use bubble insertion; 0 never stalls on hazards
- CNTW, 16, width of bubble counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-high (asserted = 1)
- in_valid  in  1  instruction offered by fetch
- in_ready  out  1  stage accepts instruction this cycle
- instruction  in  IW  opcode = [IW-1 -: 7], DA = next RAW bits below, then AA, then BA
- flush  in  1  kill the held decode and refuse input this cycle
- out_valid  out  1  control word valid to execute
- out_ready  in  1  execute consumes control word
- RW, PS, MW, MB, MA, CS  out  1 each  registered controls
- MD, BS  out  2 each  registered controls
- FS  out  4  registered function select
- DA, AA, BA  out  RAW each  registered register addresses
- illegal_sticky  out  1  set by any accepted undefined opcode
- bubble_cnt  out  CNTW  saturating count of hazard bubbles

## Operation
- Decode table: all unlisted fields are 0, including former don't-cares. FS = opcode[3:0] for every legal opcode.
  - 0000000 NOP: all controls 0.
  - Register ALU ops 0000010, 0000101, 0001000, 0001001, 0001010, 0001011, 0001100, 0001101, 0001110, 1000000: RW=1, MD=00.
  - Immediate ops 0100010, 0100101: RW=1, MB=1, CS=1.
  - Immediate ops 0101000, 0101001, 0101010, 1000010, 1000101: RW=1, MB=1, CS=0.
  - 0010000 LD: RW=1, MD=01.
  - 0100000 ST: MW=1.
  - 1100101 SLT: RW=1, MD=10.
  - 1110000 JMR: BS=10.
  - 1100000 BZ: BS=01, MB=1, CS=1.
  - 1001000 BNZ: BS=01, PS=1, MB=1, CS=1.
  - 1101000 JMP: BS=11, MB=1, CS=1.
  - 0110000 JML: RW=1, BS=11, MB=1, MA=1, CS=1.
  - Any other opcode: decoded as NOP and sets illegal_sticky when accepted.
- DA/AA/BA are passed through from the instruction fields for every accepted instruction, including NOP and illegal.
- use_a (instruction reads AA): every legal non-NOP opcode except 0001100, 1101000, 0110000.
- use_b (instruction reads BA): 0000010, 0000101, 0001000, 0001001, 0001010, 0001100, 0100000, 1100101.
- Hazard (combinational, registered state only): HAZARD_EN && out_valid && held word is LD && in_valid && ((use_a && AA_in==DA) || (use_b && BA_in==DA)).
- in_ready = !rst_n_asserted && !flush && !hazard && (!out_valid || out_ready).
- Register update:
  - On accept, the decoded word is loaded and out_valid<=1.
  - Otherwise, if out_ready, out_valid<=0 and all controls return to 0.
  - Otherwise, hold.
- Flush has priority over everything except reset: out_valid<=0, all controls/addresses<=0, no accept that cycle, and counters unchanged.
- bubble_cnt increments in each cycle where hazard && out_ready && !flush. It saturates at all-ones.

## Timing
- Reset: out_valid, all controls, DA/AA/BA, illegal_sticky and bubble_cnt go to 0. in_ready=0 while reset is asserted. Reset mid-transfer drops the held word.
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready=1 and there is no hazard.
- Load-use: exactly one bubble (one out_valid=0 cycle) with out_ready held 1. The dependent instruction is accepted the cycle after the LD is consumed.
- With out_ready=0 the held word is stable and in_ready=0. Hazard does not double-count bubbles while execute is stalled.
- flush together with out_ready=1 or in_valid=1: flush wins.
- bubble_cnt at all-ones stays all-ones.

## Test plan
- Reset, then stream NOP, 0000010 (DA=3, AA=1, BA=2), 0100010 with out_ready=1 -> out_valid rises one cycle after the first accept; the second word shows RW=1, MD=00, FS=0010, MB=0, DA=3, AA=1, BA=2; the third shows MB=1, CS=1.
- LD DA=4, then 0000101 with AA=4 -> one bubble cycle, then SUB is issued; bubble_cnt=1. Repeat with HAZARD_EN=0 -> no bubble, bubble_cnt=0.
- LD DA=4, then 0001100 with AA=4, BA=7 -> no bubble, since SHL does not read A.
- Hold out_ready=0 for 3 cycles with a valid word -> outputs stable and in_ready=0; release -> next word issued the following cycle.
- Assert flush while holding a valid BZ word with in_valid=1 -> next cycle out_valid=0, BS=00, and the input was not accepted.
- Accept opcode 1111111 -> NOP controls, illegal_sticky=1 until reset. 2^CNTW+3 forced hazards -> bubble_cnt saturates at all-ones.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: decodes an instruction into datapath controls held
// behind a valid/ready output register, with flush, load-use bubbles and sticky error counters.
module decode_stage #(
    parameter int IW        = 32,
    parameter int RAW       = 5,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNTW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   instruction,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            RW,
    output logic            PS,
    output logic            MW,
    output logic            MB,
    output logic            MA,
    output logic            CS,
    output logic [1:0]      MD,
    output logic [1:0]      BS,
    output logic [3:0]      FS,
    output logic [RAW-1:0]  DA,
    output logic [RAW-1:0]  AA,
    output logic [RAW-1:0]  BA,
    output logic            illegal_sticky,
    output logic [CNTW-1:0] bubble_cnt
);

    typedef struct packed {
        logic       rw;
        logic       ps;
        logic       mw;
        logic       mb;
        logic       ma;
        logic       cs;
        logic [1:0] md;
        logic [1:0] bs;
        logic [3:0] fs;
    } ctrl_t;

    logic [6:0]     opcode;
    logic [RAW-1:0] da_in, aa_in, ba_in;
    ctrl_t          dec;
    logic           legal, use_a, use_b, hazard, accept;

    ctrl_t          ctrl_q, ctrl_d;
    logic           valid_q, valid_d;
    logic [RAW-1:0] da_q, da_d, aa_q, aa_d, ba_q, ba_d;
    logic           illegal_q, illegal_d;
    logic [CNTW-1:0] bubble_q, bubble_d;

    assign opcode = instruction[IW-1 -: 7];
    assign da_in  = instruction[IW-8 -: RAW];
    assign aa_in  = instruction[IW-8-RAW -: RAW];
    assign ba_in  = instruction[IW-8-2*RAW -: RAW];

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        use_a = 1'b1;
        use_b = 1'b0;
        case (opcode)
            7'b0000000: use_a = 1'b0;
            7'b0000010, 7'b0000101, 7'b0001000, 7'b0001001, 7'b0001010,
            7'b0001011, 7'b0001100, 7'b0001101, 7'b0001110, 7'b1000000:
                dec.rw = 1'b1;
            7'b0100010, 7'b0100101: begin
                dec.rw = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1;
            end
            7'b0101000, 7'b0101001, 7'b0101010, 7'b1000010, 7'b1000101: begin
                dec.rw = 1'b1; dec.mb = 1'b1;
            end
            7'b0010000: begin dec.rw = 1'b1; dec.md = 2'b01; end
            7'b0100000: dec.mw = 1'b1;
            7'b1100101: begin dec.rw = 1'b1; dec.md = 2'b10; end
            7'b1110000: dec.bs = 2'b10;
            7'b1100000: begin dec.bs = 2'b01; dec.mb = 1'b1; dec.cs = 1'b1; end
            7'b1001000: begin
                dec.bs = 2'b01; dec.ps = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1;
            end
            7'b1101000: begin dec.bs = 2'b11; dec.mb = 1'b1; dec.cs = 1'b1; end
            7'b0110000: begin
                dec.rw = 1'b1; dec.bs = 2'b11; dec.mb = 1'b1; dec.ma = 1'b1; dec.cs = 1'b1;
            end
            default: begin legal = 1'b0; use_a = 1'b0; end
        endcase
        if (legal) dec.fs = opcode[3:0];
        if (opcode inside {7'b0001100, 7'b1101000, 7'b0110000}) use_a = 1'b0;
        use_b = opcode inside {7'b0000010, 7'b0000101, 7'b0001000, 7'b0001001,
                               7'b0001010, 7'b0001100, 7'b0100000, 7'b1100101};
    end

    // Only a held load (MD=01 is unique to LD) can create a load-use dependency.
    assign hazard = HAZARD_EN && valid_q && (ctrl_q.md == 2'b01) && in_valid &&
                    ((use_a && (aa_in == da_q)) || (use_b && (ba_in == da_q)));
    assign in_ready = !rst_n && !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        da_d      = da_q;
        aa_d      = aa_q;
        ba_d      = ba_q;
        illegal_d = illegal_q;
        bubble_d  = bubble_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            da_d    = '0;
            aa_d    = '0;
            ba_d    = '0;
        end else begin
            if (accept) begin
                valid_d   = 1'b1;
                ctrl_d    = dec;
                da_d      = da_in;
                aa_d      = aa_in;
                ba_d      = ba_in;
                illegal_d = illegal_q || !legal;
            end else if (out_ready) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            // A stalled execute keeps the hazard pending without producing extra bubbles.
            if (hazard && out_ready && (bubble_q != '1)) bubble_d = bubble_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            da_q      <= '0;
            aa_q      <= '0;
            ba_q      <= '0;
            illegal_q <= 1'b0;
            bubble_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            da_q      <= da_d;
            aa_q      <= aa_d;
            ba_q      <= ba_d;
            illegal_q <= illegal_d;
            bubble_q  <= bubble_d;
        end
    end

    assign out_valid      = valid_q;
    assign RW             = ctrl_q.rw;
    assign PS             = ctrl_q.ps;
    assign MW             = ctrl_q.mw;
    assign MB             = ctrl_q.mb;
    assign MA             = ctrl_q.ma;
    assign CS             = ctrl_q.cs;
    assign MD             = ctrl_q.md;
    assign BS             = ctrl_q.bs;
    assign FS             = ctrl_q.fs;
    assign DA             = da_q;
    assign AA             = aa_q;
    assign BA             = ba_q;
    assign illegal_sticky = illegal_q;
    assign bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-computed control words,
// monitors pop and compare them whenever a word is transferred to execute.
module tb_decode_stage;

    typedef struct packed {
        logic       rw, ps, mw, mb, ma, cs;
        logic [1:0] md, bs;
        logic [3:0] fs;
        logic [4:0] da, aa, ba;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic        in_ready, out_valid, RW, PS, MW, MB, MA, CS, illegal_sticky;
    logic [1:0]  MD, BS;
    logic [3:0]  FS;
    logic [4:0]  DA, AA, BA;
    logic [3:0]  bubble_cnt;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [31:0] instruction2 = '0;
    logic        in_ready2, out_valid2, RW2, PS2, MW2, MB2, MA2, CS2, illegal_sticky2;
    logic [1:0]  MD2, BS2;
    logic [3:0]  FS2;
    logic [4:0]  DA2, AA2, BA2;
    logic [15:0] bubble_cnt2;

    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    word_t exp_q[$];
    word_t exp2_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decode_stage #(.IW(32), .RAW(5), .HAZARD_EN(1'b1), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RW(RW), .PS(PS), .MW(MW), .MB(MB), .MA(MA), .CS(CS), .MD(MD), .BS(BS), .FS(FS),
        .DA(DA), .AA(AA), .BA(BA), .illegal_sticky(illegal_sticky), .bubble_cnt(bubble_cnt)
    );

    decode_stage #(.IW(32), .RAW(5), .HAZARD_EN(1'b0), .CNTW(16)) dut_nohaz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .instruction(instruction2), .flush(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
        .RW(RW2), .PS(PS2), .MW(MW2), .MB(MB2), .MA(MA2), .CS(CS2), .MD(MD2), .BS(BS2), .FS(FS2),
        .DA(DA2), .AA(AA2), .BA(BA2), .illegal_sticky(illegal_sticky2), .bubble_cnt(bubble_cnt2)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] da, aa, ba);
        return {op, da, aa, ba, 10'b0};
    endfunction

    function automatic word_t mkw(input logic rw, ps, mw, mb, ma, cs, input logic [1:0] md, bs,
                                  input logic [3:0] fs, input logic [4:0] da, aa, ba);
        return {rw, ps, mw, mb, ma, cs, md, bs, fs, da, aa, ba};
    endfunction

    function automatic word_t cur_word();
        return {RW, PS, MW, MB, MA, CS, MD, BS, FS, DA, AA, BA};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one instruction, wait (bounded) for acceptance, then drop in_valid after the edge.
    task automatic applyStimulus(input logic [31:0] instr, input word_t exp, input bit push);
        int n = 0;
        in_valid    = 1'b1;
        instruction = instr;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        else if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) checkOutput("unexpected_word", 32'(cur_word()), 32'd0);
            else checkOutput("word", 32'(cur_word()), 32'(exp_q.pop_front()));
        end
        if (!rst_n && out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) checkOutput("unexpected_word2", 32'd1, 32'd0);
            else checkOutput("word2", 32'({RW2, PS2, MW2, MB2, MA2, CS2, MD2, BS2, FS2, DA2, AA2, BA2}),
                             32'(exp2_q.pop_front()));
        end
    end

    // Every accepted instruction must be presented one cycle later.
    logic accepted_prev = 1'b0;
    always @(negedge clk) begin
        if (accepted_prev) checkOutput("latency", 32'(out_valid), 32'd1);
        accepted_prev = in_valid && in_ready && !rst_n;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word_t ld, sub;
        int    exp_cnt, t0;
        ld  = mkw(1,0,0,0,0,0, 2'b01, 2'b00, 4'h0, 5'd4, 5'd9, 5'd0);
        sub = mkw(1,0,0,0,0,0, 2'b00, 2'b00, 4'h5, 5'd6, 5'd4, 5'd8);

        idle(1);
        @(negedge clk);
        checkOutput("in_ready_during_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_word", 32'(cur_word()), 32'd0);
        checkOutput("reset_illegal", 32'(illegal_sticky), 32'd0);
        checkOutput("reset_bubble", 32'(bubble_cnt), 32'd0);

        out_ready = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        applyStimulus(mk(7'b0000000, 1, 2, 3), mkw(0,0,0,0,0,0, 0, 0, 4'h0, 1, 2, 3), 1);
        applyStimulus(mk(7'b0000010, 3, 1, 2), mkw(1,0,0,0,0,0, 0, 0, 4'h2, 3, 1, 2), 1);
        applyStimulus(mk(7'b0100010, 5, 6, 7), mkw(1,0,0,1,0,1, 0, 0, 4'h2, 5, 6, 7), 1);
        applyStimulus(mk(7'b1001000, 0, 3, 0), mkw(0,1,0,1,0,1, 0, 2'b01, 4'h8, 0, 3, 0), 1);
        applyStimulus(mk(7'b0110000, 7, 1, 0), mkw(1,0,0,1,1,1, 0, 2'b11, 4'h0, 7, 1, 0), 1);
        applyStimulus(mk(7'b1100101, 2, 3, 4), mkw(1,0,0,0,0,0, 2'b10, 0, 4'h5, 2, 3, 4), 1);
        applyStimulus(mk(7'b1000101, 8, 9, 10), mkw(1,0,0,1,0,0, 0, 0, 4'h5, 8, 9, 10), 1);
        applyStimulus(mk(7'b1101000, 0, 0, 0), mkw(0,0,0,1,0,1, 0, 2'b11, 4'h8, 0, 0, 0), 1);
        checkOutput("throughput_cycles", 32'(cyc - t0), 32'd8);
        idle(2);

        // Load-use: one bubble, dependent SUB follows
        applyStimulus(mk(7'b0010000, 4, 9, 0), ld, 1);
        in_valid = 1'b1; instruction = mk(7'b0000101, 6, 4, 8); exp_q.push_back(sub);
        @(negedge clk);
        checkOutput("hazard_in_ready", 32'(in_ready), 32'd0);
        checkOutput("ld_presented", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bubble_valid", 32'(out_valid), 32'd0);
        checkOutput("post_bubble_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("sub_issued", 32'(out_valid), 32'd1);
        checkOutput("bubble_cnt_one", 32'(bubble_cnt), 32'd1);
        idle(2);

        // SHL does not read A, so no bubble
        applyStimulus(mk(7'b0010000, 4, 9, 0), ld, 1);
        in_valid = 1'b1; instruction = mk(7'b0001100, 2, 4, 7);
        exp_q.push_back(mkw(1,0,0,0,0,0, 0, 0, 4'hC, 2, 4, 7));
        @(negedge clk);
        checkOutput("shl_no_hazard", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);
        checkOutput("bubble_cnt_after_shl", 32'(bubble_cnt), 32'd1);

        // Execute stall holds the word and blocks input
        out_ready = 1'b0;
        applyStimulus(mk(7'b0100000, 1, 2, 3), mkw(0,0,1,0,0,0, 0, 0, 4'h0, 1, 2, 3), 1);
        in_valid = 1'b1; instruction = mk(7'b1110000, 0, 5, 0);
        exp_q.push_back(mkw(0,0,0,0,0,0, 0, 2'b10, 4'h0, 0, 5, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_word", 32'(cur_word()),
                        32'(mkw(0,0,1,0,0,0, 0, 0, 4'h0, 1, 2, 3)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("jmr_after_release", 32'(cur_word()),
                    32'(mkw(0,0,0,0,0,0, 0, 2'b10, 4'h0, 0, 5, 0)));
        idle(2);

        // Flush kills a held BZ and refuses the offered instruction
        out_ready = 1'b0;
        applyStimulus(mk(7'b1100000, 0, 3, 0), '0, 0);
        in_valid = 1'b1; instruction = mk(7'b0001000, 1, 2, 3); flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_bs", 32'(BS), 32'd0);
        checkOutput("flush_word", 32'(cur_word()), 32'd0);
        out_ready = 1'b1;
        idle(1);

        // Illegal opcode
        checkOutput("illegal_clear", 32'(illegal_sticky), 32'd0);
        applyStimulus(mk(7'b1111111, 7, 8, 9), mkw(0,0,0,0,0,0, 0, 0, 4'h0, 7, 8, 9), 1);
        idle(3);
        checkOutput("illegal_set", 32'(illegal_sticky), 32'd1);

        // Forced hazards up to and past saturation (CNTW=4)
        exp_cnt = 1;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(mk(7'b0010000, 4, 9, 0), ld, 1);
            applyStimulus(mk(7'b0000101, 6, 4, 8), sub, 1);
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            @(negedge clk);
            checkOutput("bubble_cnt_sat", 32'(bubble_cnt), 32'(exp_cnt));
            @(posedge clk); #1;
        end
        checkOutput("illegal_still_set", 32'(illegal_sticky), 32'd1);
        idle(2);

        // Reset while a word is held drops it and clears counters
        out_ready = 1'b0;
        applyStimulus(mk(7'b0001001, 1, 1, 1), '0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_word", 32'(cur_word()), 32'd0);
        checkOutput("midreset_illegal", 32'(illegal_sticky), 32'd0);
        checkOutput("midreset_bubble", 32'(bubble_cnt), 32'd0);
        out_ready = 1'b1;

        // HAZARD_EN=0 instance: dependent SUB goes straight through
        @(posedge clk); #1;
        in_valid2 = 1'b1; instruction2 = mk(7'b0010000, 4, 9, 0);
        @(negedge clk);
        checkOutput("nohaz_ld_ready", 32'(in_ready2), 32'd1);
        exp2_q.push_back(ld);
        @(posedge clk); #1;
        instruction2 = mk(7'b0000101, 6, 4, 8);
        @(negedge clk);
        checkOutput("nohaz_sub_ready", 32'(in_ready2), 32'd1);
        exp2_q.push_back(sub);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("nohaz_no_bubble", 32'(out_valid2), 32'd1);
        idle(2);
        checkOutput("nohaz_bubble_cnt", 32'(bubble_cnt2), 32'd0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("scoreboard2_drained", 32'(exp2_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
